// File: rtl/arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : arbiter_pkg                                                   |
// | Purpose  : Shared types for the fetch/data memory port arbiter.          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package arbiter_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } mem_owner_t;

  typedef struct packed {
    logic       valid;
    mem_owner_t owner;
  } return_slot_t;

  localparam return_slot_t SLOT_EMPTY = '{valid: 1'b0, owner: OWNER_INSTR};

endpackage
`default_nettype wire

// File: rtl/return_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : return_pipe                                                   |
// | Purpose  : DEPTH-stage shift register tracking owners of in-flight reads.|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module return_pipe
  import arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  return_slot_t i_slot,
  output return_slot_t o_slot
);

  return_slot_t r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= SLOT_EMPTY;
      end
    end else begin
      r_stage[0] <= i_slot;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_slot = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/memory_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : memory_port_arbiter                                           |
// | Purpose  : Shares one memory port between fetch and data, routes returns.|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module memory_port_arbiter
  import arbiter_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  addr_t       instr_addr,
  output logic        instr_gnt,
  output logic        instr_rvalid,
  output data_t       instr_rdata,
  input  logic        data_req,
  input  addr_t       data_addr,
  input  data_t       data_wdata,
  input  logic [3:0]  data_we,
  output logic        data_gnt,
  output logic        data_rvalid,
  output data_t       data_rdata,
  output addr_t       mem_address,
  output data_t       mem_write_data,
  output logic [3:0]  mem_write_enable,
  input  data_t       mem_read_data,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  logic [3:0]   r_starve_cnt;
  logic [2:0]   r_loads_out;
  logic         w_force_instr;
  logic         w_instr_gnt;
  logic         w_data_gnt;
  logic         w_data_load;
  logic         w_instr_ret;
  logic         w_data_ret;
  return_slot_t w_slot_in;
  return_slot_t w_slot_out;

  always_comb begin
    w_force_instr    = instr_req && (r_starve_cnt == c_starve_limit);
    w_data_gnt       = !reset && data_req && !w_force_instr;
    w_instr_gnt      = !reset && instr_req && !w_data_gnt;
    w_data_load      = w_data_gnt && (data_we == 4'b0000);

    w_slot_in.valid  = w_instr_gnt || w_data_load;
    w_slot_in.owner  = w_data_load ? OWNER_DATA : OWNER_INSTR;

    w_instr_ret      = !reset && w_slot_out.valid && (w_slot_out.owner == OWNER_INSTR);
    w_data_ret       = !reset && w_slot_out.valid && (w_slot_out.owner == OWNER_DATA);

    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 4'b0000;
    if (w_data_gnt) begin
      mem_address      = data_addr;
      mem_write_data   = data_wdata;
      mem_write_enable = data_we;
    end else if (w_instr_gnt) begin
      mem_address      = instr_addr;
    end

    instr_gnt    = w_instr_gnt;
    data_gnt     = w_data_gnt;
    instr_rvalid = w_instr_ret;
    data_rvalid  = w_data_ret;
    instr_rdata  = w_instr_ret ? mem_read_data : '0;
    data_rdata   = w_data_ret  ? mem_read_data : '0;
    stall_if     = !reset && instr_req && !w_instr_gnt;
    // A load returning this cycle no longer holds the memory stage.
    stall_mem    = !reset && ((data_req && !w_data_gnt) ||
                              (r_loads_out > 3'(w_data_ret)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= 4'd0;
    end else if (instr_req && !w_instr_gnt) begin
      if (r_starve_cnt != c_starve_limit) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end else begin
      r_starve_cnt <= 4'd0;
    end
  end

  // Outstanding-load count; data_load_pending is any non-zero value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_loads_out <= 3'd0;
    end else begin
      r_loads_out <= r_loads_out + 3'(w_data_load) - 3'(w_data_ret);
    end
  end

  return_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_return_pipe (
    .clk    (clk),
    .reset  (reset),
    .i_slot (w_slot_in),
    .o_slot (w_slot_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_memory_port_arbiter                                        |
// | Purpose  : Vector table + return scoreboard for latency 1 and 3 arbiters.|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_memory_port_arbiter;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [31:0] da;
    logic [31:0] dw;
    logic [3:0]  we;
    logic        eig;
    logic        edg;
  } vec_t;

  typedef struct {
    logic        own;
    logic [31:0] data;
    int          due;
  } ret_t;

  typedef struct packed {
    logic        ig;
    logic        dg;
    logic        irv;
    logic        drv;
    logic        sif;
    logic        smem;
    logic [3:0]  mwe;
    logic [31:0] ird;
    logic [31:0] drd;
    logic [31:0] ma;
    logic [31:0] mwd;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = '0;
  logic        data_req = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [3:0]  data_we = '0;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  ret_t q [2][$];
  logic [31:0] g_mem [256];
  logic [31:0] m [2][256];
  logic [31:0] rd [2][3];

  logic        ig [2], dg [2], irv [2], drv [2], sif [2], smem [2];
  logic [3:0]  mwe [2];
  logic [31:0] ird [2], drd [2], ma [2], mwd [2];
  obs_t        ob [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    memory_port_arbiter #(
      .MEM_LATENCY  (LAT),
      .STARVE_LIMIT (4)
    ) u_dut (
      .clk              (clk),
      .reset            (reset),
      .instr_req        (instr_req),
      .instr_addr       (instr_addr),
      .instr_gnt        (ig[g]),
      .instr_rvalid     (irv[g]),
      .instr_rdata      (ird[g]),
      .data_req         (data_req),
      .data_addr        (data_addr),
      .data_wdata       (data_wdata),
      .data_we          (data_we),
      .data_gnt         (dg[g]),
      .data_rvalid      (drv[g]),
      .data_rdata       (drd[g]),
      .mem_address      (ma[g]),
      .mem_write_data   (mwd[g]),
      .mem_write_enable (mwe[g]),
      .mem_read_data    (rd[g][LAT-1]),
      .stall_if         (sif[g]),
      .stall_mem        (smem[g])
    );
    assign ob[g] = '{ig: ig[g], dg: dg[g], irv: irv[g], drv: drv[g], sif: sif[g],
                     smem: smem[g], mwe: mwe[g], ird: ird[g], drd: drd[g],
                     ma: ma[g], mwd: mwd[g]};

    // Environment memory: writes land at the edge, reads arrive LAT cycles later.
    always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
        if (mwe[g][b]) m[g][ma[g][9:2]][8*b +: 8] <= mwd[g][8*b +: 8];
      end
      rd[g][0] <= m[g][ma[g][9:2]];
      rd[g][1] <= rd[g][0];
      rd[g][2] <= rd[g][1];
    end
  end

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic void chk(int k, string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [latency %0d] at cycle %0d: got %0h, expected %0h",
               nm, lat_of(k), cyc, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic [31:0] da,
                              logic [31:0] dw, logic [3:0] we, logic eig, logic edg);
    vec_t v;
    v = '{ir, ia, dr, da, dw, we, eig, edg};
    return v;
  endfunction

  function automatic logic load_outstanding(int k);
    foreach (q[k][i]) if (q[k][i].own && q[k][i].due > cyc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void push_ret(logic own, logic [31:0] d);
    for (int k = 0; k < 2; k++) q[k].push_back('{own: own, data: d, due: cyc + lat_of(k)});
  endfunction

  // Return scoreboard: every rvalid must match the oldest expected return.
  function automatic void mon(int k);
    ret_t e;
    chk(k, "single_rvalid", 32'(ob[k].irv & ob[k].drv), 32'h0);
    if (ob[k].irv || ob[k].drv) begin
      if (q[k].size() == 0) begin
        chk(k, "spurious_rvalid", 32'h1, 32'h0);
      end else begin
        e = q[k].pop_front();
        chk(k, "rvalid_owner", 32'(ob[k].drv), 32'(e.own));
        chk(k, "rvalid_cycle", cyc, e.due);
        chk(k, "rdata", ob[k].drv ? ob[k].drd : ob[k].ird, e.data);
      end
    end else if (q[k].size() > 0 && q[k][0].due <= cyc) begin
      chk(k, "missing_rvalid", 32'h0, 32'h1);
      void'(q[k].pop_front());
    end
    if (!ob[k].irv) chk(k, "instr_rdata_idle", ob[k].ird, 32'h0);
    if (!ob[k].drv) chk(k, "data_rdata_idle", ob[k].drd, 32'h0);
  endfunction

  always @(negedge clk) for (int k = 0; k < 2; k++) mon(k);

  // Requesters must hold request and payload until granted.
  logic        p_ip = 1'b0, p_dp = 1'b0;
  logic [31:0] p_ia = '0, p_da = '0, p_dw = '0;
  logic [3:0]  p_we = '0;
  always @(posedge clk) begin
    if (!reset && p_ip)
      assert (instr_req && instr_addr == p_ia) else $error("protocol: fetch request changed before grant");
    if (!reset && p_dp)
      assert (data_req && data_addr == p_da && data_wdata == p_dw && data_we == p_we)
        else $error("protocol: data request changed before grant");
    p_ip <= !reset && instr_req && !ob[0].ig;
    p_dp <= !reset && data_req && !ob[0].dg;
    p_ia <= instr_addr;
    p_da <= data_addr;
    p_dw <= data_wdata;
    p_we <= data_we;
  end

  task automatic drive(input vec_t v);
    instr_req  = v.ir;
    instr_addr = v.ia;
    data_req   = v.dr;
    data_addr  = v.da;
    data_wdata = v.dw;
    data_we    = v.we;
  endtask

  task automatic step(input vec_t v);
    logic [31:0] ea, ewd;
    logic [3:0]  ewe;
    drive(v);
    @(negedge clk);
    ea  = v.edg ? v.da : (v.eig ? v.ia : 32'h0);
    ewe = v.edg ? v.we : 4'h0;
    ewd = v.edg ? v.dw : 32'h0;
    for (int k = 0; k < 2; k++) begin
      chk(k, "instr_gnt", 32'(ob[k].ig), 32'(v.eig));
      chk(k, "data_gnt", 32'(ob[k].dg), 32'(v.edg));
      chk(k, "mem_address", ob[k].ma, ea);
      chk(k, "mem_write_enable", 32'(ob[k].mwe), 32'(ewe));
      chk(k, "mem_write_data", ob[k].mwd, ewd);
      chk(k, "stall_if", 32'(ob[k].sif), 32'(v.ir && !v.eig));
      chk(k, "stall_mem", 32'(ob[k].smem),
          32'((v.dr && !v.edg) || load_outstanding(k)));
    end
    if (v.eig) push_ret(1'b0, g_mem[v.ia[9:2]]);
    if (v.edg && v.we == 4'h0) push_ret(1'b1, g_mem[v.da[9:2]]);
    if (v.edg) for (int b = 0; b < 4; b++) if (v.we[b]) g_mem[v.da[9:2]][8*b +: 8] = v.dw[8*b +: 8];
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    reset = 1'b1;
    for (int k = 0; k < 2; k++)
      while (q[k].size() > 0 && q[k][$].due >= cyc) void'(q[k].pop_back());
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(k, "reset_gnts", {30'h0, ob[k].ig, ob[k].dg}, 32'h0);
      chk(k, "reset_rvalids", {30'h0, ob[k].irv, ob[k].drv}, 32'h0);
      chk(k, "reset_stalls", {30'h0, ob[k].sif, ob[k].smem}, 32'h0);
      chk(k, "reset_mem_address", ob[k].ma, 32'h0);
      chk(k, "reset_mem_we", 32'(ob[k].mwe), 32'h0);
      chk(k, "reset_mem_wdata", ob[k].mwd, 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [13];
    vec_t        idle;
    logic [31:0] ia_s, da_s;
    logic        fw;

    for (int i = 0; i < 256; i++) begin
      g_mem[i] = 32'hA500_0000 | (i << 2);
      m[0][i]  = g_mem[i];
      m[1][i]  = g_mem[i];
    end
    idle    = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0]  = mk(1, 32'h000, 0, 0, 0, 4'h0, 1, 0);
    tbl[1]  = mk(1, 32'h004, 0, 0, 0, 4'h0, 1, 0);
    tbl[2]  = mk(1, 32'h008, 0, 0, 0, 4'h0, 1, 0);
    tbl[3]  = mk(1, 32'h00C, 1, 32'h100, 0, 4'h0, 0, 1);
    tbl[4]  = mk(1, 32'h00C, 0, 0, 0, 4'h0, 1, 0);
    tbl[5]  = idle;
    tbl[6]  = mk(0, 0, 1, 32'h104, 0, 4'h0, 0, 1);
    tbl[7]  = mk(0, 0, 1, 32'h108, 32'h1234_5678, 4'b0011, 0, 1);
    tbl[8]  = mk(1, 32'h108, 0, 0, 0, 4'h0, 1, 0);
    tbl[9]  = idle;
    tbl[10] = mk(1, 32'h010, 1, 32'h10C, 32'hCAFE_F00D, 4'hF, 0, 1);
    tbl[11] = mk(1, 32'h010, 0, 0, 0, 4'h0, 1, 0);
    tbl[12] = idle;

    // Reset with both requests active: nothing may be granted.
    drive(mk(1, 32'h44, 1, 32'h88, 32'h1, 4'h0, 0, 0));
    for (int i = 0; i < 3; i++) reset_cycle();
    reset = 1'b0;
    drive(idle);
    @(posedge clk);
    #1;

    foreach (tbl[i]) step(tbl[i]);

    // Data held for 10 cycles against a waiting fetch: fetch forced on 5th and 10th.
    ia_s = 32'h40;
    da_s = 32'h180;
    for (int j = 0; j < 10; j++) begin
      fw = (j == 4) || (j == 9);
      step(mk(1, ia_s, 1, da_s, 0, 4'h0, fw, !fw));
      if (fw) ia_s += 4; else da_s += 4;
    end
    step(mk(1, ia_s, 1, da_s, 0, 4'h0, 0, 1));
    step(mk(1, ia_s, 0, 0, 0, 4'h0, 1, 0));
    repeat (4) step(idle);

    // Full-word store then load of the same address.
    step(mk(0, 0, 1, 32'h200, 32'hDEAD_BEEF, 4'hF, 0, 1));
    step(mk(0, 0, 1, 32'h200, 0, 4'h0, 0, 1));
    repeat (4) step(idle);

    // Interleaved reads on consecutive cycles.
    step(mk(1, 32'h020, 0, 0, 0, 4'h0, 1, 0));
    step(mk(0, 0, 1, 32'h204, 0, 4'h0, 0, 1));
    step(mk(1, 32'h024, 0, 0, 0, 4'h0, 1, 0));
    step(mk(0, 0, 1, 32'h208, 0, 4'h0, 0, 1));
    step(mk(1, 32'h028, 0, 0, 0, 4'h0, 1, 0));
    repeat (4) step(idle);

    // Reset while two reads are in flight: their returns must be dropped.
    step(mk(1, 32'h030, 0, 0, 0, 4'h0, 1, 0));
    step(mk(0, 0, 1, 32'h034, 0, 4'h0, 0, 1));
    drive(mk(1, 32'h038, 1, 32'h03C, 0, 4'h0, 0, 0));
    reset_cycle();
    reset_cycle();
    reset = 1'b0;
    repeat (6) step(idle);
    step(mk(1, 32'h02C, 0, 0, 0, 4'h0, 1, 0));
    repeat (4) step(idle);

    for (int k = 0; k < 2; k++) chk(k, "scoreboard_drained", q[k].size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
